pipe_ctrl: RTL

- Central stall/flush scheduler for the 5-stage pipeline.
- Collects stall requests from IF, ID, EX and MEM, branch-mispredict flushes from EX, and fence-style drain requests from ID.
- Drives the per-stage stall vector and flush line consumed by all inter-stage registers (pc_reg, if_id, id_ex, ex_mem, mem_wb), plus the PC redirect.
- Stall vector is combinational (zero latency); flush/redirect sequencing is a registered FSM.

---
 rtl/pipe_ctrl_if.sv | 53 +++++
 rtl/pipe_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush scheduler.
// Carries stage requests (stall, flush, drain) into the scheduler and the
// stall vector, flush line, PC redirect and drain status back out.
//
// Ports (as signals):
//   rdy_in          global ready; 0 freezes the whole pipeline
//   stallreq_if     IF not ready (icache miss)
//   stallreq_id     load-use hazard in ID
//   stallreq_ex     multi-cycle EX op
//   stallreq_mem    memory access in progress
//   flushreq_ex     branch mispredict detected in EX
//   flush_target    correct PC for flushreq_ex
//   drainreq_id     fence/fence.i in ID needs the back end empty
//   stall           per-stage hold, bit0=PC .. bit5=WB
//   flush           if_id/id_ex load a bubble
//   redirect_valid  one-cycle pulse, PC loads redirect_pc
//   redirect_pc     latched flush_target
//   drain_done      one-cycle pulse at end of a drain
//   stall_cnt       number of cycles with stall[0]=1
interface pipe_ctrl_if #(
    parameter int PIPE_DEPTH = 6,
    parameter int ADDR_W     = 32
);
    logic                  rdy_in;
    logic                  stallreq_if;
    logic                  stallreq_id;
    logic                  stallreq_ex;
    logic                  stallreq_mem;
    logic                  flushreq_ex;
    logic [ADDR_W-1:0]     flush_target;
    logic                  drainreq_id;

    logic [PIPE_DEPTH-1:0] stall;
    logic                  flush;
    logic                  redirect_valid;
    logic [ADDR_W-1:0]     redirect_pc;
    logic                  drain_done;
    logic [31:0]           stall_cnt;

    // Pipeline side: raises requests, consumes control.
    modport master (
        output rdy_in, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
               flushreq_ex, flush_target, drainreq_id,
        input  stall, flush, redirect_valid, redirect_pc, drain_done, stall_cnt
    );

    // Scheduler side: consumes requests, drives control.
    modport slave (
        input  rdy_in, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
               flushreq_ex, flush_target, drainreq_id,
        output stall, flush, redirect_valid, redirect_pc, drain_done, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Purpose: central stall/flush/drain scheduler for the 5-stage pipeline.
// Latency: stall vector is combinational (0 cycles); flush, redirect and drain_done are registered (1 cycle).
// Backpressure: rdy_in=0 or stallreq_mem=1 freezes the flush/drain counters and defers entry into FLUSH.
//
// Ports:
//   clk   clock, all state on posedge
//   rst   asynchronous active-low reset
//   pc    pipe_ctrl_if.slave bundle (requests in, stall/flush/redirect/drain out)
module pipe_ctrl #(
    parameter int PIPE_DEPTH   = 6,
    parameter int FLUSH_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int ADDR_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   pc
);

    localparam int FCW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [FCW-1:0]     flush_cnt, flush_cnt_nx;
    logic [DCW-1:0]     drain_cnt, drain_cnt_nx;
    logic [ADDR_W-1:0]  redirect_pc_q, redirect_pc_nx;
    logic               redirect_valid_q, redirect_valid_nx;
    logic               drain_done_q, drain_done_nx;
    logic [31:0]        stall_cnt_q;
    logic [PIPE_DEPTH-1:0] stall_vec;

    // Counters only advance when the whole pipe is actually moving; a memory
    // stall also freezes EX, so a mispredict held there keeps its request up.
    logic advance;
    logic flush_go;
    logic drain_go;

    assign advance  = pc.rdy_in && !pc.stallreq_mem;
    assign flush_go = pc.flushreq_ex && advance;
    assign drain_go = pc.drainreq_id && !pc.flushreq_ex && pc.rdy_in &&
                      !pc.stallreq_mem && !pc.stallreq_ex;

    // Contiguous stall prefix: stages [n-1:0] hold, everything above runs on.
    function automatic logic [PIPE_DEPTH-1:0] low_ones(input int n);
        logic [PIPE_DEPTH-1:0] m;
        m = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Stall vector. IF/ID requests are ignored outside RUN: during FLUSH
    // they belong to squashed instructions, and DRAIN already holds the
    // front end.
    // ------------------------------------------------------------------
    always_comb begin
        stall_vec = '0;
        if (!rst) begin
            stall_vec = '0;
        end else if (!pc.rdy_in) begin
            stall_vec = '1;
        end else if (pc.stallreq_mem) begin
            stall_vec = low_ones(5);
        end else if (pc.stallreq_ex) begin
            stall_vec = low_ones(4);
        end else if ((pc.stallreq_id && state == RUN) || state == DRAIN) begin
            stall_vec = low_ones(3);
        end else if (pc.stallreq_if && state == RUN) begin
            stall_vec = low_ones(2);
        end
    end

    // ------------------------------------------------------------------
    // Flush / drain sequencing: next-state and next-output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx          = state;
        flush_cnt_nx      = flush_cnt;
        drain_cnt_nx      = drain_cnt;
        redirect_pc_nx    = redirect_pc_q;
        redirect_valid_nx = 1'b0;
        drain_done_nx     = 1'b0;

        case (state)
            RUN: begin
                // A mispredict outranks a drain: the fence is squashed with it.
                if (flush_go) begin
                    state_nx          = FLUSH;
                    flush_cnt_nx      = FCW'(FLUSH_CYCLES);
                    redirect_pc_nx    = pc.flush_target;
                    redirect_valid_nx = 1'b1;
                end else if (drain_go) begin
                    state_nx     = DRAIN;
                    drain_cnt_nx = DCW'(DRAIN_CYCLES);
                end
            end

            FLUSH: begin
                if (advance) begin
                    flush_cnt_nx = flush_cnt - FCW'(1);
                    if (flush_cnt == FCW'(1)) begin
                        state_nx = RUN;
                    end
                end
            end

            DRAIN: begin
                // Mispredict aborts the drain without reporting completion.
                if (flush_go) begin
                    state_nx          = FLUSH;
                    flush_cnt_nx      = FCW'(FLUSH_CYCLES);
                    drain_cnt_nx      = '0;
                    redirect_pc_nx    = pc.flush_target;
                    redirect_valid_nx = 1'b1;
                end else if (advance) begin
                    drain_cnt_nx = drain_cnt - DCW'(1);
                    if (drain_cnt == DCW'(1)) begin
                        state_nx      = RUN;
                        drain_done_nx = 1'b1;
                    end
                end
            end

            default: begin
                state_nx     = RUN;
                flush_cnt_nx = '0;
                drain_cnt_nx = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= RUN;
            flush_cnt        <= '0;
            drain_cnt        <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            drain_done_q     <= 1'b0;
        end else begin
            state            <= state_nx;
            flush_cnt        <= flush_cnt_nx;
            drain_cnt        <= drain_cnt_nx;
            redirect_pc_q    <= redirect_pc_nx;
            redirect_valid_q <= redirect_valid_nx;
            drain_done_q     <= drain_done_nx;
        end
    end

    // Free-running count of PC-stalled cycles; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_vec[0]) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // flush comes straight from the state flop, so flushreq_ex never reaches
    // it combinationally.
    assign pc.stall          = stall_vec;
    assign pc.flush          = (state == FLUSH);
    assign pc.redirect_valid = redirect_valid_q;
    assign pc.redirect_pc    = redirect_pc_q;
    assign pc.drain_done     = drain_done_q;
    assign pc.stall_cnt      = stall_cnt_q;

endmodule
